// File: rtl/music_ps2_pkg.sv
// rtl/music_ps2_pkg.sv - PS/2 Set 2 prefix codes, ignore list and frame FSM encoding
`timescale 1ns/1ps
package music_ps2_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;

  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_OVR_LO = 8'h00;
  localparam logic [7:0] PS2_OVR_HI = 8'hFF;

  localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  // Keyboard housekeeping bytes that never carry a key event.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ECHO) || (b == PS2_OVR_LO) || (b == PS2_OVR_HI);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchroniser and glitch filter for the PS/2 clock and data lines
`timescale 1ns/1ps
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clock,
  input  logic resetn,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic clk_f,
  output logic dat_s,
  output logic fall
);
  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clk_f_q, fall_q;
  logic                   clk_s, differ, toggle;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign differ = (clk_s != clk_f_q);
  // The filtered clock flips only on the FILTER_LEN-th consecutive disagreeing sample.
  assign toggle = differ && (cnt_q == CNT_W'(FILTER_LEN - 1));

  always_comb begin
    cnt_d = '0;
    if (differ && !toggle) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      cnt_q      <= '0;
      clk_f_q    <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
      cnt_q      <= cnt_d;
      fall_q     <= toggle && clk_f_q;
      if (toggle) clk_f_q <= ~clk_f_q;
    end
  end

  assign clk_f = clk_f_q;
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 frame receiver and Set 2 prefix decoder producing scan code plus make/break
`timescale 1ns/1ps
module ps2_scan_decoder
  import music_ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] keyboard_code,
  output logic       makeBreak,
  output logic       code_valid,
  output logic       frame_err
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic            clk_f_w, dat_s_w, fall_w, edge_w;
  frame_state_e    state_q, state_d;
  logic [2:0]      bit_cnt_q, skip_q;
  logic [7:0]      shreg_q, code_q;
  logic            par_q, brk_q, ext_q, mb_q, valid_q, err_q;
  logic [TO_W-1:0] to_q;
  logic            timeout_w, byte_ok_w, frame_bad_w, stop_edge_w;

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filt (
    .clock  (clock),
    .resetn (resetn),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .clk_f  (clk_f_w),
    .dat_s  (dat_s_w),
    .fall   (fall_w)
  );

  assign edge_w = fall_w & ~clk_f_w;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (edge_w) begin
      case (state_q)
        ST_IDLE:   if (!dat_s_w) state_d = ST_DATA;
        ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        default:   state_d = ST_IDLE;
      endcase
    end else if (timeout_w) begin
      state_d = ST_IDLE;
    end
  end

  // A fall in the same cycle as the timeout wins, so timeout is masked by edge_w.
  always_comb begin
    stop_edge_w = edge_w && (state_q == ST_STOP);
    timeout_w   = !edge_w && (state_q != ST_IDLE) && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
    byte_ok_w   = stop_edge_w && dat_s_w && (^{shreg_q, par_q});
    frame_bad_w = (stop_edge_w && !(dat_s_w && (^{shreg_q, par_q}))) || timeout_w;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      to_q      <= '0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      skip_q    <= '0;
      code_q    <= 8'h00;
      mb_q      <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= frame_bad_w;
      if ((state_q == ST_IDLE) || edge_w) to_q <= '0;
      else                                to_q <= to_q + 1'b1;

      if (edge_w) begin
        case (state_q)
          ST_IDLE:   bit_cnt_q <= '0;
          ST_DATA: begin
            shreg_q   <= {dat_s_w, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          ST_PARITY: par_q <= dat_s_w;
          default:   ;
        endcase
      end

      if (frame_bad_w) begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end

      if (byte_ok_w) begin
        if (skip_q != 3'd0)              skip_q <= skip_q - 3'd1;
        else if (shreg_q == PS2_PAUSE)   skip_q <= PAUSE_TAIL_LEN;
        else if (shreg_q == PS2_BREAK)   brk_q  <= 1'b1;
        else if (shreg_q == PS2_EXT)     ext_q  <= 1'b1;
        else if (!is_ignored(shreg_q)) begin
          if (!ext_q) begin
            code_q  <= shreg_q;
            mb_q    <= ~brk_q;
            valid_q <= 1'b1;
          end
          brk_q <= 1'b0;
          ext_q <= 1'b0;
        end
      end
    end
  end

  assign keyboard_code = code_q;
  assign makeBreak     = mb_q;
  assign code_valid    = valid_q;
  assign frame_err     = err_q;

endmodule
